// File: rtl/ap3_dsp_pkg.sv
// Shared definitions for AP3 DSP hard-block sequencers: FSM states,
// DSP select encodings and datapath widths.
package ap3_dsp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    RESULT
  } state_t;

  localparam logic [1:0] DSP_MODE_MAC    = 2'b00;
  localparam logic [1:0] DSP_OUT_SEL_ACC = 2'b00;

  localparam int unsigned DSP_DATA_W = 32;
  localparam int unsigned DSP_ACC_W  = 64;

endpackage

// File: rtl/dsp_mac_sequencer.sv
// Sequences one AP3 DSP block in MAC mode: clears the accumulator, streams
// LEN coefficient/operand pairs into it, waits out its latency, returns the sum.
module dsp_mac_sequencer
  import ap3_dsp_pkg::*;
#(
  parameter int unsigned LEN_W   = 10,
  parameter int unsigned DSP_LAT = 2,
  parameter logic [1:0]  MODE    = DSP_MODE_MAC
) (
  input  logic                  CLOCK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic [LEN_W-1:0]      LEN,
  input  logic                  CFG_RND,
  input  logic                  CFG_SAT,
  input  logic                  ABORT,
  output logic                  BUSY,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DSP_DATA_W-1:0] IN_COEF,
  input  logic [DSP_DATA_W-1:0] IN_OPER,
  output logic                  RES_VALID,
  input  logic                  RES_READY,
  output logic [DSP_ACC_W-1:0]  RES_DATA,
  output logic [1:0]            DSP_MODE_SEL,
  output logic [1:0]            DSP_OUT_SEL,
  output logic [DSP_DATA_W-1:0] DSP_COEF_DATA,
  output logic [DSP_DATA_W-1:0] DSP_OPER_DATA,
  output logic                  DSP_ENABLE,
  output logic                  DSP_CLR,
  output logic                  DSP_RND,
  output logic                  DSP_SAT,
  input  logic [DSP_ACC_W-1:0]  DSP_MAC_OUT
);

  localparam int unsigned LAT_W = $clog2(DSP_LAT + 1);

  state_t           state;
  logic [LEN_W-1:0] tap_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic             job_live;

  assign DSP_MODE_SEL = MODE;
  assign DSP_OUT_SEL  = DSP_OUT_SEL_ACC;

  // ABORT masks ready combinationally so an aborting cycle never completes a pair.
  assign IN_READY = (state == ACCUM) & ~ABORT;

  assign job_live = (state == CLEAR) || (state == ACCUM) || (state == DRAIN);

  always_ff @(posedge CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= IDLE;
      tap_cnt       <= '0;
      lat_cnt       <= '0;
      BUSY          <= 1'b0;
      RES_VALID     <= 1'b0;
      RES_DATA      <= '0;
      DSP_COEF_DATA <= '0;
      DSP_OPER_DATA <= '0;
      DSP_ENABLE    <= 1'b0;
      DSP_CLR       <= 1'b0;
      DSP_RND       <= 1'b0;
      DSP_SAT       <= 1'b0;
    end else begin
      DSP_ENABLE <= 1'b0;
      DSP_CLR    <= 1'b0;
      if (ABORT && job_live) begin
        // Clear the partial sum so the DSP is clean for the next job.
        DSP_CLR <= 1'b1;
        BUSY    <= 1'b0;
        state   <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (START) begin
              BUSY <= 1'b1;
              if (LEN != '0) begin
                tap_cnt <= LEN;
                DSP_RND <= CFG_RND;
                DSP_SAT <= CFG_SAT;
                DSP_CLR <= 1'b1;
                state   <= CLEAR;
              end else begin
                RES_DATA  <= '0;
                RES_VALID <= 1'b1;
                state     <= RESULT;
              end
            end
          end
          CLEAR: state <= ACCUM;
          ACCUM: begin
            if (IN_VALID) begin
              DSP_COEF_DATA <= IN_COEF;
              DSP_OPER_DATA <= IN_OPER;
              DSP_ENABLE    <= 1'b1;
              tap_cnt       <= tap_cnt - 1'b1;
              if (tap_cnt == LEN_W'(1)) begin
                lat_cnt <= LAT_W'(DSP_LAT);
                state   <= DRAIN;
              end
            end
          end
          DRAIN: begin
            if (lat_cnt == '0) begin
              RES_DATA  <= DSP_MAC_OUT;
              RES_VALID <= 1'b1;
              state     <= RESULT;
            end else begin
              lat_cnt <= lat_cnt - 1'b1;
            end
          end
          RESULT: begin
            if (ABORT || RES_READY) begin
              RES_VALID <= 1'b0;
              BUSY      <= 1'b0;
              state     <= IDLE;
            end
          end
          default: begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Scoreboard bench for dsp_mac_sequencer driving a behavioural MAC model
// with DSP_LAT cycles of latency.
module tb_dsp_mac_sequencer;

  localparam int unsigned LEN_W   = 10;
  localparam int unsigned DSP_LAT = 2;

  logic             CLOCK     = 1'b0;
  logic             RST_N     = 1'b0;
  logic             START     = 1'b0;
  logic [LEN_W-1:0] LEN       = '0;
  logic             CFG_RND   = 1'b0;
  logic             CFG_SAT   = 1'b0;
  logic             ABORT     = 1'b0;
  logic             IN_VALID  = 1'b0;
  logic [31:0]      IN_COEF   = '0;
  logic [31:0]      IN_OPER   = '0;
  logic             RES_READY = 1'b1;
  logic             BUSY, IN_READY, RES_VALID;
  logic [63:0]      RES_DATA, DSP_MAC_OUT;
  logic [1:0]       DSP_MODE_SEL, DSP_OUT_SEL;
  logic [31:0]      DSP_COEF_DATA, DSP_OPER_DATA;
  logic             DSP_ENABLE, DSP_CLR, DSP_RND, DSP_SAT;

  always #5 CLOCK = ~CLOCK;

  dsp_mac_sequencer #(.LEN_W(LEN_W), .DSP_LAT(DSP_LAT), .MODE(2'b00)) dut (
    .CLOCK(CLOCK), .RST_N(RST_N), .START(START), .LEN(LEN),
    .CFG_RND(CFG_RND), .CFG_SAT(CFG_SAT), .ABORT(ABORT), .BUSY(BUSY),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_COEF(IN_COEF), .IN_OPER(IN_OPER),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_DATA(RES_DATA),
    .DSP_MODE_SEL(DSP_MODE_SEL), .DSP_OUT_SEL(DSP_OUT_SEL),
    .DSP_COEF_DATA(DSP_COEF_DATA), .DSP_OPER_DATA(DSP_OPER_DATA),
    .DSP_ENABLE(DSP_ENABLE), .DSP_CLR(DSP_CLR), .DSP_RND(DSP_RND), .DSP_SAT(DSP_SAT),
    .DSP_MAC_OUT(DSP_MAC_OUT)
  );

  // Behavioural DSP: accumulator register followed by DSP_LAT-1 output stages.
  logic [63:0] acc;
  logic [63:0] pipe [DSP_LAT];
  always @(posedge CLOCK) begin
    logic [63:0] nxt;
    if (DSP_CLR)         nxt = 64'd0;
    else if (DSP_ENABLE) nxt = acc + 64'(DSP_COEF_DATA) * 64'(DSP_OPER_DATA);
    else                 nxt = acc;
    acc     <= nxt;
    pipe[0] <= nxt;
    for (int i = 1; i < DSP_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign DSP_MAC_OUT = pipe[DSP_LAT-1];

  int          checks = 0;
  int          errors = 0;
  int          en_cnt = 0;
  int          clr_cnt = 0;
  int          res_cnt = 0;
  logic [63:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected event, required the awaited event", name);
  endtask

  // Monitor: pulse counters and scoreboard pop on every result handshake.
  always @(negedge CLOCK) begin
    if (RST_N) begin
      en_cnt  += int'(DSP_ENABLE);
      clr_cnt += int'(DSP_CLR);
    end
    if (RES_VALID && RES_READY) begin
      res_cnt++;
      if (exp_q.size() == 0) fail("unexpected_result");
      else chk("res_data", RES_DATA, exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic start_job(input int len, input bit rnd, input bit sat);
    START   = 1'b1;
    LEN     = LEN_W'(len);
    CFG_RND = rnd;
    CFG_SAT = sat;
    tick();
    START = 1'b0;
  endtask

  task automatic send_pair(input logic [31:0] c, input logic [31:0] o,
                           input bit chk_hold, input logic [31:0] pc, input logic [31:0] po);
    bit hs;
    IN_VALID = 1'b1;
    IN_COEF  = c;
    IN_OPER  = o;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLOCK);
      hs = IN_READY;
      if (chk_hold && k == 0) begin
        chk("gap_enable_low", 64'(DSP_ENABLE), 64'd0);
        chk("gap_data_held", {DSP_COEF_DATA, DSP_OPER_DATA}, {pc, po});
      end
      tick();
      if (hs) begin
        IN_VALID = 1'b0;
        return;
      end
    end
    IN_VALID = 1'b0;
    fail("pair_handshake_timeout");
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 60; k++) begin
      tick();
      if (!BUSY) return;
    end
    fail(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] c3 [3];
    logic [31:0] o3 [3];
    logic [4:0]  got, expv;
    bit          hs;
    int          idx, en_b, clr_b, res_b;
    c3 = '{32'd2, 32'd4, 32'd6};
    o3 = '{32'd3, 32'd5, 32'd7};

    // Reset state
    #12;
    chk("reset_ctrl", 64'({BUSY, IN_READY, RES_VALID, DSP_ENABLE, DSP_CLR, DSP_RND, DSP_SAT}), 64'd0);
    chk("reset_res_data", RES_DATA, 64'd0);
    chk("reset_dsp_data", {DSP_COEF_DATA, DSP_OPER_DATA}, 64'd0);
    chk("mode_outsel", 64'({DSP_MODE_SEL, DSP_OUT_SEL}), 64'd0);
    #5 RST_N = 1'b1;
    tick();

    // Test 1: cycle-exact timeline, LEN=3 back-to-back
    exp_q.push_back(64'd68);
    START = 1'b1; LEN = LEN_W'(3); CFG_RND = 1'b1; CFG_SAT = 1'b0;
    IN_VALID = 1'b1; IN_COEF = c3[0]; IN_OPER = o3[0];
    idx = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLOCK);
      hs   = IN_VALID & IN_READY;
      got  = {DSP_CLR, DSP_ENABLE, hs, RES_VALID, BUSY};
      expv = {k == 1, k >= 3 && k <= 5, k >= 2 && k <= 4, k == 8, k >= 1 && k <= 8};
      chk($sformatf("t1_cycle%0d_clr_en_hs_rv_busy", k), 64'(got), 64'(expv));
      tick();
      START = 1'b0;
      if (hs) begin
        idx++;
        if (idx < 3) begin IN_COEF = c3[idx]; IN_OPER = o3[idx]; end
        else IN_VALID = 1'b0;
      end
    end
    chk("t1_rnd_sat_latched", 64'({DSP_RND, DSP_SAT}), 64'd2);

    // Test 2: same job with gaps between pairs
    en_b = en_cnt;
    exp_q.push_back(64'd68);
    start_job(3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      send_pair(c3[i], o3[i], i > 0, (i > 0) ? c3[(i > 0) ? i-1 : 0] : 32'd0,
                (i > 0) ? o3[(i > 0) ? i-1 : 0] : 32'd0);
    end
    wait_idle("t2_idle_timeout");
    chk("t2_enable_pulses", 64'(en_cnt - en_b), 64'd3);

    // Test 3: result back-pressure, START ignored while holding the result
    clr_b = clr_cnt;
    RES_READY = 1'b0;
    exp_q.push_back(64'd26);
    start_job(2, 1'b0, 1'b0);
    send_pair(32'd2, 32'd3, 1'b0, 32'd0, 32'd0);
    send_pair(32'd4, 32'd5, 1'b0, 32'd0, 32'd0);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
        if (RES_VALID) seen = 1'b1;
        else tick();
      end
      if (!seen) fail("t3_res_valid_timeout");
    end
    for (int k = 0; k < 5; k++) begin
      START = 1'b1; LEN = LEN_W'(1);
      @(negedge CLOCK);
      chk($sformatf("t3_hold%0d_rv_busy", k), 64'({RES_VALID, BUSY}), 64'd3);
      chk($sformatf("t3_hold%0d_data", k), RES_DATA, 64'd26);
      tick();
    end
    RES_READY = 1'b1;
    tick();
    START = 1'b0;
    chk("t3_idle_after_release", 64'({BUSY, RES_VALID}), 64'd0);
    tick(); tick(); tick();
    chk("t3_start_ignored_busy", 64'(BUSY), 64'd0);
    chk("t3_clr_pulses", 64'(clr_cnt - clr_b), 64'd1);

    // Test 4: LEN=0 job
    en_b = en_cnt; clr_b = clr_cnt;
    exp_q.push_back(64'd0);
    start_job(0, 1'b0, 1'b0);
    @(negedge CLOCK);
    chk("t4_rv_cycle1", 64'(RES_VALID), 64'd1);
    tick();
    chk("t4_idle_cycle2", 64'(BUSY), 64'd0);
    chk("t4_no_dsp_activity", 64'({en_cnt - en_b, clr_cnt - clr_b}), 64'd0);

    // Test 5: abort after two pairs, coincident with a valid pair
    en_b = en_cnt; clr_b = clr_cnt; res_b = res_cnt;
    start_job(4, 1'b0, 1'b0);
    send_pair(32'd1, 32'd2, 1'b0, 32'd0, 32'd0);
    send_pair(32'd3, 32'd4, 1'b0, 32'd0, 32'd0);
    IN_VALID = 1'b1; IN_COEF = 32'd8; IN_OPER = 32'd8; ABORT = 1'b1;
    @(negedge CLOCK);
    chk("t5_ready_masked", 64'(IN_READY), 64'd0);
    tick();
    ABORT = 1'b0; IN_VALID = 1'b0;
    chk("t5_clr_en_busy", 64'({DSP_CLR, DSP_ENABLE, BUSY}), 64'd4);
    for (int k = 0; k < 8; k++) tick();
    chk("t5_enable_pulses", 64'(en_cnt - en_b), 64'd2);
    chk("t5_clr_pulses", 64'(clr_cnt - clr_b), 64'd2);
    chk("t5_no_result", 64'(res_cnt - res_b), 64'd0);
    exp_q.push_back(64'd81);
    start_job(1, 1'b0, 1'b0);
    send_pair(32'd9, 32'd9, 1'b0, 32'd0, 32'd0);
    wait_idle("t5_idle_timeout");

    // Test 6: asynchronous reset in DRAIN
    res_b = res_cnt;
    start_job(1, 1'b1, 1'b1);
    send_pair(32'd3, 32'd4, 1'b0, 32'd0, 32'd0);
    chk("t6_in_drain_busy_rnd_sat", 64'({BUSY, DSP_RND, DSP_SAT}), 64'd7);
    #2 RST_N = 1'b0;
    #1;
    chk("t6_async_ctrl", 64'({BUSY, IN_READY, RES_VALID, DSP_ENABLE, DSP_CLR, DSP_RND, DSP_SAT}), 64'd0);
    chk("t6_async_res_data", RES_DATA, 64'd0);
    chk("t6_async_dsp_data", {DSP_COEF_DATA, DSP_OPER_DATA}, 64'd0);
    tick(); tick();
    #2 RST_N = 1'b1;
    tick();
    chk("t6_idle_after_reset", 64'({BUSY, RES_VALID}), 64'd0);
    for (int k = 0; k < 4; k++) tick();
    chk("t6_no_stale_result", 64'(res_cnt - res_b), 64'd0);
    exp_q.push_back(64'd9);
    start_job(1, 1'b0, 1'b0);
    send_pair(32'd3, 32'd3, 1'b0, 32'd0, 32'd0);
    wait_idle("t6_idle_timeout");

    tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
